deserializer: RTL

//  Serial-to-parallel receive stage that consumes the MSB-first bit stream produced by the serializer.

---
 rtl/deser_pkg.sv | 11 +
 rtl/deserializer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/deser_pkg.sv
// Shared constants for the serial receive stage: state encoding and default sizing.
package deser_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage : deser_pkg

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel receiver with SOF framing, gap timeout and frame-error reporting.
// Optional trailing even-parity bit and parity_err_o port when DESER_PARITY_EN is defined.
module deserializer
  import deser_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_i,
  input  logic             bit_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] par_data_o,
  output logic             data_vld_o,
  output logic             frame_err_o,
`ifdef DESER_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] shreg_q,     shreg_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [GAP_W-1:0] gap_q,       gap_d;
  logic [WIDTH-1:0] par_data_q,  par_data_d;
  logic             data_vld_q,  data_vld_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q,      busy_d;
`ifdef DESER_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic             last_data_bit;
  logic             gap_expired;

  assign shifted       = {shreg_q[WIDTH-2:0], ser_i};
  assign last_data_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign gap_expired   = (TIMEOUT != 0) && (gap_q == GAP_W'(TIMEOUT - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    par_data_d  = par_data_q;
    data_vld_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef DESER_PARITY_EN
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        gap_d = '0;
        if (bit_vld && sof) begin
          shreg_d = shifted;
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT, ST_PARITY: begin
        if (bit_vld) begin
          gap_d = '0;
          // A qualified SOF always wins: abort the current frame and restart on this bit
          if (sof) begin
            frame_err_d = 1'b1;
            shreg_d     = WIDTH'(ser_i);
            cnt_d       = CNT_W'(1);
            state_d     = ST_SHIFT;
          end
`ifdef DESER_PARITY_EN
          else if (state_q == ST_PARITY) begin
            par_data_d   = shreg_q;
            data_vld_d   = 1'b1;
            parity_err_d = (ser_i != (^shreg_q));
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end
`endif
          else if (last_data_bit) begin
            shreg_d = shifted;
`ifdef DESER_PARITY_EN
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_PARITY;
`else
            par_data_d = shifted;
            data_vld_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_IDLE;
`endif
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (gap_expired) begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          gap_d       = '0;
          state_d     = ST_IDLE;
        end else if (gap_q != {GAP_W{1'b1}}) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      par_data_q  <= '0;
      data_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      par_data_q  <= par_data_d;
      data_vld_q  <= data_vld_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef DESER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign par_data_o  = par_data_q;
  assign data_vld_o  = data_vld_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = busy_q;
`ifdef DESER_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule : deserializer
